bp_cfg_loader: RTL



---
 rtl/bp_cfg_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bp_cfg_loader.sv
// Boot-time configuration sequencer: freezes each core, loads CCE mode and microcode over the
// config bus, unfreezes it, then waits for every write acknowledgement before raising done_o.
module bp_cfg_loader #(
    parameter int unsigned num_cores_p       = 1,
    parameter int unsigned cce_pc_width_p    = 8,
    parameter int unsigned ucode_els_p       = 2 ** cce_pc_width_p,
    parameter int unsigned cfg_addr_width_p  = 16,
    parameter int unsigned cfg_data_width_p  = 64,
    parameter int unsigned max_outstanding_p = 4,
    localparam int unsigned CoreW = (num_cores_p > 1) ? $clog2(num_cores_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    output logic [cce_pc_width_p-1:0]   ucode_addr_o,
    input  logic [cfg_data_width_p-1:0] ucode_data_i,

    output logic                        cmd_v_o,
    input  logic                        cmd_ready_i,
    output logic [CoreW-1:0]            cmd_core_o,
    output logic [cfg_addr_width_p-1:0] cmd_addr_o,
    output logic [cfg_data_width_p-1:0] cmd_data_o,

    input  logic                        resp_v_i,
    output logic                        resp_yumi_o,

    output logic                        done_o
);

    localparam int unsigned CredW = $clog2(max_outstanding_p + 1);

    localparam logic [CredW-1:0]            MaxCred    = CredW'(max_outstanding_p);
    localparam logic [CoreW-1:0]            LastCore   = CoreW'(num_cores_p - 1);
    localparam logic [cce_pc_width_p-1:0]   LastIdx    = cce_pc_width_p'(ucode_els_p - 1);
    localparam logic [cfg_addr_width_p-1:0] FreezeAddr = cfg_addr_width_p'(32'h0010);
    localparam logic [cfg_addr_width_p-1:0] ModeAddr   = cfg_addr_width_p'(32'h0020);
    localparam logic [cfg_addr_width_p-1:0] UcodeBase  = cfg_addr_width_p'(32'h8000);
    localparam logic [cfg_data_width_p-1:0] DataOne    = cfg_data_width_p'(1);

    typedef enum logic [3:0] {
        StReset,
        StFreeze,
        StModeUc,
        StUcodeFetch,
        StUcodeSend,
        StModeNormal,
        StUnfreeze,
        StDrain,
        StDone
    } state_e;

    state_e                    state_q, state_d;
    logic [CoreW-1:0]          core_q, core_d;
    logic [cce_pc_width_p-1:0] idx_q, idx_d;
    logic [CredW-1:0]          credits_q, credits_d;

    logic can_issue;
    logic fire;
    logic cmd_hs;
    logic resp_hs;

    assign can_issue    = (credits_q < MaxCred);
    assign fire         = can_issue & cmd_ready_i;
    assign cmd_hs       = cmd_v_o & cmd_ready_i;
    assign resp_yumi_o  = resp_v_i & ~reset_i;
    assign resp_hs      = resp_yumi_o;

    // ROM address follows the word index, so the ROM output stays valid while a send stalls.
    assign ucode_addr_o = idx_q;
    assign cmd_core_o   = core_q;
    assign done_o       = (state_q == StDone);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StReset;
            core_q    <= '0;
            idx_q     <= '0;
            credits_q <= '0;
        end else begin
            state_q   <= state_d;
            core_q    <= core_d;
            idx_q     <= idx_d;
            credits_q <= credits_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        core_d     = core_q;
        idx_d      = idx_q;
        cmd_v_o    = 1'b0;
        cmd_addr_o = '0;
        cmd_data_o = '0;

        unique case (state_q)
            StReset: begin
                state_d = StFreeze;
            end
            StFreeze: begin
                cmd_v_o    = can_issue;
                cmd_addr_o = FreezeAddr;
                cmd_data_o = DataOne;
                if (fire) state_d = StModeUc;
            end
            StModeUc: begin
                cmd_v_o    = can_issue;
                cmd_addr_o = ModeAddr;
                if (fire) state_d = StUcodeFetch;
            end
            StUcodeFetch: begin
                state_d = StUcodeSend;
            end
            StUcodeSend: begin
                cmd_v_o    = can_issue;
                cmd_addr_o = UcodeBase + cfg_addr_width_p'(idx_q);
                cmd_data_o = ucode_data_i;
                if (fire) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StModeNormal;
                    end else begin
                        idx_d   = idx_q + cce_pc_width_p'(1);
                        state_d = StUcodeFetch;
                    end
                end
            end
            StModeNormal: begin
                cmd_v_o    = can_issue;
                cmd_addr_o = ModeAddr;
                cmd_data_o = DataOne;
                if (fire) state_d = StUnfreeze;
            end
            StUnfreeze: begin
                cmd_v_o    = can_issue;
                cmd_addr_o = FreezeAddr;
                if (fire) begin
                    if (core_q == LastCore) begin
                        state_d = StDrain;
                    end else begin
                        core_d  = core_q + CoreW'(1);
                        state_d = StFreeze;
                    end
                end
            end
            StDrain: begin
                if (credits_q == '0) state_d = StDone;
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StReset;
            end
        endcase
    end

    always_comb begin
        credits_d = credits_q;
        unique case ({cmd_hs, resp_hs})
            2'b10:   credits_d = credits_q + CredW'(1);
            2'b01:   credits_d = credits_q - CredW'(1);
            default: credits_d = credits_q;
        endcase
    end

    // A response with nothing outstanding means the network acknowledged a write we never sent.
    credit_underflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
        !(resp_v_i && (credits_q == '0)));

    credit_overflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
        credits_q <= MaxCred);

endmodule
